// File: rtl/grid_uart_pkg.sv
// Shared types and constants for the grid UART debug dump: serializer states, ASCII codes,
// frame geometry and the nibble-to-hex-character mapping.
package grid_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiEsc  = 8'h1B;
  localparam logic [7:0] AsciiLbrk = 8'h5B;
  localparam logic [7:0] AsciiH    = 8'h48;

  localparam int unsigned ROW_BYTES = 6;
  localparam int unsigned HDR_BYTES = 3;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready input. Owns the bit-time counter, bit index and the
// registered tx line; ready is high only while idle.
module uart_tx_byte
  import grid_uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 87
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntLast     = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntStopLast = CntW'(ClksPerBit - 2);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  assign tx_o    = tx_q;
  assign ready_o = (state_q == StIdle);

  // The stop bit's final cycle is spent in StIdle, so a waiting byte is taken with no gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (valid_i) begin
          shift_d = data_i;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntStopLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/grid_uart_tx.sv
// Dumps the 4x4 board as ASCII hex rows over an 8N1 UART whenever it changes or on request.
// Define GRID_UART_HEADER_EN to prefix each frame with ESC [ H (cursor home).
module grid_uart_tx
  import grid_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] grid,
  input  logic        send_req,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

`ifdef GRID_UART_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic [63:0] snap_q, snap_d;
  logic [63:0] last_sent_q, last_sent_d;
  logic        req_pend_q, req_pend_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        all_sent_q, all_sent_d;
  logic        in_hdr_q, in_hdr_d;
  logic [1:0]  row_q, row_d;
  logic [2:0]  chr_q, chr_d;

  logic        trigger, byte_valid, byte_ready, accept;
  logic [7:0]  byte_data;
  logic [63:0] board;
  logic [5:0]  nib_sel;
  logic [3:0]  nib;

  assign trigger    = ~busy_q & ((grid != last_sent_q) | req_pend_q | send_req);
  assign byte_valid = trigger | (busy_q & ~all_sent_q);
  assign accept     = byte_valid & byte_ready;

  // Byte 0 leaves in the trigger cycle, before snap is loaded, so read the live bus then.
  assign board   = busy_q ? snap_q : grid;
  assign nib_sel = ~{row_q, chr_q[1:0], 2'b00};
  assign nib     = board[nib_sel -: 4];

  always_comb begin
    byte_data = hex_ascii(nib);
    if (in_hdr_q) begin
      if (chr_q == 3'd0) begin
        byte_data = AsciiEsc;
      end else if (chr_q == 3'd1) begin
        byte_data = AsciiLbrk;
      end else begin
        byte_data = AsciiH;
      end
    end else if (chr_q == 3'd4) begin
      byte_data = AsciiCr;
    end else if (chr_q == 3'd5) begin
      byte_data = AsciiLf;
    end
  end

  always_comb begin
    snap_d       = snap_q;
    last_sent_d  = last_sent_q;
    req_pend_d   = req_pend_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    all_sent_d   = all_sent_q;
    in_hdr_d     = in_hdr_q;
    row_d        = row_q;
    chr_d        = chr_q;

    if (trigger) begin
      snap_d      = grid;
      last_sent_d = grid;
      req_pend_d  = 1'b0;
      busy_d      = 1'b1;
    end else if (busy_q && send_req) begin
      req_pend_d = 1'b1;
    end

    if (accept) begin
      if (in_hdr_q) begin
        if (chr_q == 3'(HDR_BYTES - 1)) begin
          in_hdr_d = 1'b0;
          chr_d    = '0;
        end else begin
          chr_d = chr_q + 3'd1;
        end
      end else if (chr_q == 3'(ROW_BYTES - 1)) begin
        chr_d = '0;
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          all_sent_d = 1'b1;
        end
      end else begin
        chr_d = chr_q + 3'd1;
      end
    end

    // Serializer back in idle after the last byte means its stop bit ends this cycle.
    if (busy_q && all_sent_q && byte_ready) begin
      busy_d       = 1'b0;
      all_sent_d   = 1'b0;
      frame_done_d = 1'b1;
      in_hdr_d     = HdrEn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q       <= '0;
      last_sent_q  <= '0;
      req_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      all_sent_q   <= 1'b0;
      in_hdr_q     <= HdrEn;
      row_q        <= '0;
      chr_q        <= '0;
    end else begin
      snap_q       <= snap_d;
      last_sent_q  <= last_sent_d;
      req_pend_q   <= req_pend_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      all_sent_q   <= all_sent_d;
      in_hdr_q     <= in_hdr_d;
      row_q        <= row_d;
      chr_q        <= chr_d;
    end
  end

  uart_tx_byte #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(byte_valid),
    .data_i (byte_data),
    .ready_o(byte_ready),
    .tx_o   (tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grid_uart_tx.sv
// Bench for grid_uart_tx: UART receiver model feeding a byte scoreboard, table of boards,
// and hand-written sequences for mid-frame change, request collapsing and mid-frame reset.
module tb_grid_uart_tx;

  localparam int unsigned Cpb = 4;
`ifdef GRID_UART_HEADER_EN
  localparam int unsigned HdrN = 3;
`else
  localparam int unsigned HdrN = 0;
`endif
  localparam int unsigned FrameBytes = 24 + HdrN;
  localparam int FrameLat = FrameBytes * 10 * Cpb + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] grid;
  logic        send_req;
  logic        tx, busy, frame_done;

  int n_tests = 0;
  int n_fail = 0;
  int ecount = 0;
  int fd_count = 0;
  int fd_edge = 0;
  int rise_edge = 0;
  int rx_count = 0;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [63:0]  grid;
    logic [127:0] text;
  } vec_t;
  vec_t vecs[4];

  grid_uart_tx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grid      (grid),
    .send_req  (send_req),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int target, input int bound, input string name);
    int k = 0;
    while (fd_count < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(fd_count >= target), 64'd1);
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  function automatic void push_hdr();
    if (HdrN != 0) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(8'h5B);
      exp_q.push_back(8'h48);
    end
  endfunction

  // Expected frame from a literal 16-char board text.
  function automatic void push_text(input logic [127:0] text);
    push_hdr();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(text[127-8*i -: 8]);
      if (i % 4 == 3) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endfunction

  // Expected frame from a board value, truncated to the first nbytes bytes.
  function automatic void push_frame(input logic [63:0] g, input int nbytes);
    logic [7:0] fr[$];
    if (HdrN != 0) begin
      fr.push_back(8'h1B);
      fr.push_back(8'h5B);
      fr.push_back(8'h48);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) fr.push_back(asc(g[63-16*r-4*c -: 4]));
      fr.push_back(8'h0D);
      fr.push_back(8'h0A);
    end
    for (int i = 0; i < nbytes; i++) exp_q.push_back(fr[i]);
  endfunction

  // UART receiver: samples each bit mid-cell, abandons a byte when reset is seen.
  initial begin : mon
    logic [7:0] b;
    logic [7:0] e;
    bit aborted;
    int idx;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        aborted = 1'b0;
        b = '0;
        for (int k = 1; k < 10 * Cpb; k++) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k % Cpb == Cpb / 2) begin
            idx = k / Cpb;
            if (idx == 0) check("start_bit", 64'(tx), 64'd0);
            else if (idx <= 8) b[idx-1] = tx;
            else check("stop_bit", 64'(tx), 64'd1);
          end
        end
        if (!aborted) begin
          rx_count++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got %02h, want no byte", b);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rx_byte%0d", rx_count), 64'(b), 64'(e));
          end
        end
      end
    end
  end

  initial begin : fd_mon
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_edge = ecount;
        check("fd_busy_low", 64'(busy), 64'd0);
        check("fd_tx_idle", 64'(tx), 64'd1);
      end
      if (busy === 1'b1 && busy_prev === 1'b0) rise_edge = ecount;
      busy_prev = busy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int idle_bad;
    int fd0;
    int t0;
    int f1;
    logic [63:0] ga, gb, gd;

    vecs[0] = '{64'h1000_0000_0000_00BA, "10000000000000BA"};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, "0123456789ABCDEF"};
    vecs[2] = '{64'hFEDC_BA98_7654_3210, "FEDCBA9876543210"};
    vecs[3] = '{64'h2222_0000_0000_0001, "2222000000000001"};

    rst = 1'b1;
    grid = '0;
    send_req = 1'b0;
    step(3);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fd", 64'(frame_done), 64'd0);
    rst = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) idle_bad++;
    end
    check("idle_zero_board", 64'(idle_bad), 64'd0);
    check("idle_no_rx", 64'(rx_count), 64'd0);
    check("idle_no_fd", 64'(fd_count), 64'd0);

    for (int v = 0; v < 4; v++) begin
      step(1);
      push_text(vecs[v].text);
      fd0 = fd_count;
      grid = vecs[v].grid;
      t0 = ecount;
      @(negedge clk);
      check("pre_edge_tx_high", 64'(tx), 64'd1);
      @(negedge clk);
      check("start_tx_low", 64'(tx), 64'd0);
      check("start_busy", 64'(busy), 64'd1);
      wait_fd(fd0 + 1, FrameLat + 20, "frame_done_seen");
      check("frame_latency", 64'(fd_edge - t0), 64'(FrameLat));
      repeat (60) @(negedge clk);
      check("single_frame", 64'(fd_count), 64'(fd0 + 1));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end

    // Board change during byte 5: old frame completes, one follow-up with the new board.
    ga = 64'h0001_0020_0300_4000;
    gb = 64'h5678_0000_9ABC_DEF0;
    step(1);
    fd0 = fd_count;
    push_frame(ga, FrameBytes);
    grid = ga;
    step(5 * 10 * Cpb + 20);
    grid = gb;
    push_frame(gb, FrameBytes);
    wait_fd(fd0 + 1, FrameLat + 20, "chg_first_done");
    f1 = fd_edge;
    wait_fd(fd0 + 2, FrameLat + 40, "chg_second_done");
    check("chg_gap", 64'(rise_edge > f1), 64'd1);
    repeat (FrameLat + 100) @(negedge clk);
    check("chg_no_third", 64'(fd_count), 64'(fd0 + 2));
    check("chg_queue", 64'(exp_q.size()), 64'd0);

    // Request with unchanged board, then three requests collapsing into one extra frame.
    step(1);
    fd0 = fd_count;
    push_frame(gb, FrameBytes);
    send_req = 1'b1;
    step(1);
    send_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(100);
      send_req = 1'b1;
      step(1);
      send_req = 1'b0;
    end
    push_frame(gb, FrameBytes);
    wait_fd(fd0 + 1, FrameLat + 20, "req_first_done");
    wait_fd(fd0 + 2, FrameLat + 40, "req_second_done");
    repeat (FrameLat + 100) @(negedge clk);
    check("req_collapsed", 64'(fd_count), 64'(fd0 + 2));
    check("req_queue", 64'(exp_q.size()), 64'd0);

    // Reset in a data bit of byte 10, then restart from byte 0.
    gd = 64'hC0FF_EE00_1234_ABCD;
    step(1);
    fd0 = fd_count;
    push_frame(gd, 10);
    grid = gd;
    step(10 * 10 * Cpb + 4 * Cpb);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 64'(tx), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    step(3);
    check("mid_rst_no_fd", 64'(fd_count), 64'(fd0));
    check("mid_rst_rx10", 64'(exp_q.size()), 64'd0);
    push_frame(gd, FrameBytes);
    rst = 1'b0;
    t0 = ecount;
    wait_fd(fd0 + 1, FrameLat + 20, "restart_done");
    check("restart_latency", 64'(fd_edge - t0), 64'(FrameLat));
    repeat (20) @(negedge clk);
    check("restart_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
